// File: rtl/ks_seq_pkg.sv
// Shared types for the Karplus-Strong note sequencer: FSM states and the step-table entry.
package ks_seq_pkg;

  localparam int LEN_WIDTH    = 4;
  localparam int PERIOD_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [PERIOD_WIDTH-1:0] period;
    logic [LEN_WIDTH-1:0]    len;
    logic                    accent;
  } step_entry_t;

endpackage

// File: rtl/ks_seq_if.sv
// Step-table write port between the register map (master) and the sequencer (slave).
interface ks_seq_wr_if
  import ks_seq_pkg::*;
#(
  parameter int AW         = 3,
  parameter int DATA_WIDTH = 8
) ();

  // wr_en_i acts as valid with an implicit ready of 1: every strobe is
  // accepted in the cycle it is seen, whatever state the sequencer is in.
  logic                  wr_en_i;
  logic [AW-1:0]         wr_addr_i;
  logic [DATA_WIDTH-1:0] wr_period_i;
  logic [LEN_WIDTH-1:0]  wr_len_i;
  logic                  wr_accent_i;

  modport master (
    output wr_en_i, wr_addr_i, wr_period_i, wr_len_i, wr_accent_i
  );

  modport slave (
    input wr_en_i, wr_addr_i, wr_period_i, wr_len_i, wr_accent_i
  );

endinterface

// File: rtl/ks_seq_step_mem.sv
// Step table: NUM_STEPS entries, one synchronous write port, one combinational read port.
// The accent bit is only kept when KS_SEQ_ACCENT_EN is defined.
module ks_seq_step_mem
  import ks_seq_pkg::*;
#(
  parameter  int NUM_STEPS = 8,
  localparam int AW        = $clog2(NUM_STEPS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ks_seq_wr_if.slave        wr,
  input  logic [AW-1:0]     rd_addr_i,
  output step_entry_t       rd_entry_o
);

  step_entry_t mem_q [NUM_STEPS];
  step_entry_t wr_entry;

  always_comb begin
    wr_entry        = '0;
    wr_entry.period = PERIOD_WIDTH'(wr.wr_period_i);
    wr_entry.len    = wr.wr_len_i;
`ifdef KS_SEQ_ACCENT_EN
    wr_entry.accent = wr.wr_accent_i;
`endif
  end

`ifndef KS_SEQ_ACCENT_EN
  logic unused_wr_accent;
  assign unused_wr_accent = wr.wr_accent_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr.wr_en_i) begin
      mem_q[wr.wr_addr_i] <= wr_entry;
    end
  end

  // Combinational read: a write landing on the same edge as a LOAD is seen by the next LOAD.
  assign rd_entry_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ks_note_sequencer.sv
// Step sequencer for ks_string: loads each table step's period, plucks, and times steps in sample ticks.
// Optional KS_SEQ_ACCENT_EN drives dynamics_en_o from the per-step accent bit.
module ks_note_sequencer
  import ks_seq_pkg::*;
#(
  parameter  int NUM_STEPS  = 8,
  parameter  int DATA_WIDTH = 8,
  parameter  int DUR_WIDTH  = 8,
  parameter  int PLUCK_LEN  = 4,
  localparam int AW         = $clog2(NUM_STEPS),
  localparam int SW         = AW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sample_tick_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  loop_en_i,
  input  logic [SW-1:0]         num_steps_i,
  input  logic [DUR_WIDTH-1:0]  tempo_i,
  ks_seq_wr_if.slave            wr,
  output logic [DATA_WIDTH-1:0] period_o,
  output logic                  pluck_o,
  output logic                  dynamics_en_o,
  output logic                  busy_o,
  output logic [AW-1:0]         step_o,
  output logic                  done_o,
  output seq_state_t            state_o
);

  localparam int DCW = LEN_WIDTH + DUR_WIDTH;
  localparam int PCW = $clog2(PLUCK_LEN + 1);

  seq_state_t            state_q, state_d;
  logic [AW-1:0]         step_q, step_d;
  logic [DATA_WIDTH-1:0] period_q, period_d;
  logic                  pluck_q, pluck_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DCW-1:0]        dur_q, dur_d;
  logic [PCW-1:0]        pcnt_q, pcnt_d;

  step_entry_t           rd_entry;
  logic [SW-1:0]         steps_eff;
  logic [AW-1:0]         last_step;
  logic [LEN_WIDTH-1:0]  len_eff;
  logic [DUR_WIDTH-1:0]  tempo_eff;

  ks_seq_step_mem #(.NUM_STEPS(NUM_STEPS)) u_mem (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr         (wr),
    .rd_addr_i  (step_q),
    .rd_entry_o (rd_entry)
  );

  // Zero-valued controls collapse to their minimum meaningful value.
  always_comb begin
    steps_eff = num_steps_i;
    if (num_steps_i == '0) begin
      steps_eff = SW'(1);
    end else if (num_steps_i > SW'(NUM_STEPS)) begin
      steps_eff = SW'(NUM_STEPS);
    end
    last_step = AW'(steps_eff - SW'(1));
    len_eff   = (rd_entry.len == '0) ? LEN_WIDTH'(1) : rd_entry.len;
    tempo_eff = (tempo_i == '0) ? DUR_WIDTH'(1) : tempo_i;
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    period_d = period_q;
    pluck_d  = pluck_q;
    done_d   = 1'b0;
    dur_d    = dur_q;
    pcnt_d   = pcnt_q;

    unique case (state_q)
      ST_IDLE: begin
        pluck_d = 1'b0;
        if (start_i) begin
          state_d = ST_LOAD;
          step_d  = '0;
        end
      end

      ST_LOAD: begin
        if (rd_entry.period != '0) begin
          period_d = DATA_WIDTH'(rd_entry.period);
          pluck_d  = 1'b1;
        end else begin
          pluck_d  = 1'b0;
        end
        dur_d   = DCW'(len_eff) * DCW'(tempo_eff);
        pcnt_d  = PCW'(PLUCK_LEN);
        state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (sample_tick_i) begin
          if (dur_q == DCW'(1)) begin
            pluck_d = 1'b0;
            // >= rather than == so a shrunken num_steps_i still ends the pass.
            if (step_q >= last_step) begin
              if (loop_en_i) begin
                step_d  = '0;
                state_d = ST_LOAD;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              step_d  = step_q + AW'(1);
              state_d = ST_LOAD;
            end
          end else begin
            dur_d = dur_q - DCW'(1);
            if (pcnt_q != '0) begin
              pcnt_d = pcnt_q - PCW'(1);
            end
            if (pcnt_q <= PCW'(1)) begin
              pluck_d = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        pluck_d = 1'b0;
      end
    endcase

    if (stop_i) begin
      state_d  = ST_IDLE;
      step_d   = step_q;
      period_d = period_q;
      pluck_d  = 1'b0;
      done_d   = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      period_q <= '0;
      pluck_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dur_q    <= '0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      period_q <= period_d;
      pluck_q  <= pluck_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dur_q    <= dur_d;
      pcnt_q   <= pcnt_d;
    end
  end

`ifdef KS_SEQ_ACCENT_EN
  logic dyn_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dyn_q <= 1'b0;
    end else if (state_q == ST_LOAD && !stop_i) begin
      dyn_q <= rd_entry.accent;
    end
  end

  assign dynamics_en_o = dyn_q;
`else
  logic unused_accent;
  assign unused_accent = rd_entry.accent;
  assign dynamics_en_o = 1'b0;
`endif

  assign period_o = period_q;
  assign pluck_o  = pluck_q;
  assign busy_o   = busy_q;
  assign step_o   = step_q;
  assign done_o   = done_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Directed bench for ks_note_sequencer; expected pluck periods flow through a scoreboard queue.
module tb_ks_note_sequencer;
  import ks_seq_pkg::*;

  localparam int NUM_STEPS  = 8;
  localparam int DATA_WIDTH = 8;
  localparam int DUR_WIDTH  = 8;
  localparam int PLUCK_LEN  = 4;
  localparam int AW         = 3;
  localparam int SW         = 4;
`ifdef KS_SEQ_ACCENT_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  sample_tick = 1'b0;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic                  loop_en = 1'b0;
  logic [SW-1:0]         num_steps = '0;
  logic [DUR_WIDTH-1:0]  tempo = '0;
  logic [DATA_WIDTH-1:0] period;
  logic                  pluck, dyn, busy, done;
  logic [AW-1:0]         step;
  seq_state_t            state;

  ks_seq_wr_if #(.AW(AW), .DATA_WIDTH(DATA_WIDTH)) wif ();

  ks_note_sequencer #(
    .NUM_STEPS(NUM_STEPS), .DATA_WIDTH(DATA_WIDTH),
    .DUR_WIDTH(DUR_WIDTH), .PLUCK_LEN(PLUCK_LEN)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sample_tick_i(sample_tick),
    .start_i(start), .stop_i(stop), .loop_en_i(loop_en),
    .num_steps_i(num_steps), .tempo_i(tempo), .wr(wif),
    .period_o(period), .pluck_o(pluck), .dynamics_en_o(dyn),
    .busy_o(busy), .step_o(step), .done_o(done), .state_o(state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [DATA_WIDTH-1:0] exp_p;
  logic                  pluck_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Every pluck rising edge consumes one expected period.
  always @(negedge clk) begin
    if (!rst && pluck === 1'b1 && pluck_prev === 1'b0) begin
      if (exp_q.size() != 0) exp_p = exp_q.pop_front();
      else exp_p = 'x;
      chk("sb_pluck_period", 32'(period), 32'(exp_p));
    end
    pluck_prev = pluck;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic end_tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DATA_WIDTH-1:0] p,
                    input logic [3:0] l, input logic acc);
    wif.wr_en_i     = 1'b1;
    wif.wr_addr_i   = a;
    wif.wr_period_i = p;
    wif.wr_len_i    = l;
    wif.wr_accent_i = acc;
    cyc();
    wif.wr_en_i     = 1'b0;
  endtask

  task automatic start_play();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("load_state", 32'(state), 32'(ST_LOAD));
    cyc();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    wif.wr_en_i = 1'b0; wif.wr_addr_i = '0; wif.wr_period_i = '0;
    wif.wr_len_i = '0; wif.wr_accent_i = 1'b0;
    rst = 1'b1;
    repeat (2) cyc();
    chk("rst_period", 32'(period), 32'h0);
    chk("rst_pluck", 32'(pluck), 32'h0);
    chk("rst_dyn", 32'(dyn), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    rst = 1'b0;
    cyc();

    // single note: 2 units x tempo 5 = 10 ticks
    wr(0, 8'h40, 4'd2, 1'b0);
    tempo = 8'd5; num_steps = 4'd1; loop_en = 1'b0;
    exp_q.push_back(8'h40);
    start_play();
    chk("t2_period", 32'(period), 32'h40);
    chk("t2_pluck_on", 32'(pluck), 32'h1);
    chk("t2_busy", 32'(busy), 32'h1);
    run_ticks(3);
    chk("t2_pluck_hold", 32'(pluck), 32'h1);
    run_ticks(1);
    chk("t2_pluck_off", 32'(pluck), 32'h0);
    run_ticks(5);
    chk("t2_no_early_done", 32'(done), 32'h0);
    end_tick();
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_idle_busy", 32'(busy), 32'h0);
    chk("t2_period_held", 32'(period), 32'h40);
    cyc();
    chk("t2_done_pulse", 32'(done), 32'h0);

    // short step: pluck truncated by a 2-tick step
    wr(0, 8'h22, 4'd1, 1'b0);
    tempo = 8'd2; loop_en = 1'b1;
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h22);
    start_play();
    chk("t4_pluck_on", 32'(pluck), 32'h1);
    run_ticks(1);
    chk("t4_pluck_mid", 32'(pluck), 32'h1);
    end_tick();
    chk("t4_trunc", 32'(pluck), 32'h0);
    chk("t4_load", 32'(state), 32'(ST_LOAD));
    cyc();
    chk("t4_repluck", 32'(pluck), 32'h1);
    do_stop();
    chk("t4_stop_state", 32'(state), 32'(ST_IDLE));
    chk("t4_stop_pluck", 32'(pluck), 32'h0);

    // loop with a rest step, tempo 8
    wr(0, 8'h30, 4'd1, 1'b0);
    wr(1, 8'h00, 4'd1, 1'b0);
    wr(2, 8'h50, 4'd1, 1'b0);
    tempo = 8'd8; num_steps = 4'd3; loop_en = 1'b1;
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h30);
    start_play();
    chk("t3_step0_period", 32'(period), 32'h30);
    run_ticks(7);
    end_tick();
    chk("t3_step1", 32'(step), 32'h1);
    chk("t3_gap_pluck", 32'(pluck), 32'h0);
    cyc();
    chk("t3_rest_pluck", 32'(pluck), 32'h0);
    chk("t3_rest_period", 32'(period), 32'h30);
    run_ticks(7);
    end_tick();
    cyc();
    chk("t3_step2", 32'(step), 32'h2);
    chk("t3_step2_period", 32'(period), 32'h50);
    run_ticks(7);
    end_tick();
    chk("t3_wrap_step", 32'(step), 32'h0);
    chk("t3_wrap_no_done", 32'(done), 32'h0);
    cyc();
    chk("t3_wrap_period", 32'(period), 32'h30);
    run_ticks(1);
    do_stop();
    chk("t3_stop_state", 32'(state), 32'(ST_IDLE));
    chk("t3_stop_pluck", 32'(pluck), 32'h0);
    chk("t3_stop_busy", 32'(busy), 32'h0);
    chk("t3_stop_period", 32'(period), 32'h30);
    chk("t3_stop_no_done", 32'(done), 32'h0);

    // edge inputs: zero tempo, zero length, zero num_steps
    wr(0, 8'h11, 4'd0, 1'b1);
    tempo = 8'd0; num_steps = 4'd0; loop_en = 1'b0;
    exp_q.push_back(8'h11);
    start_play();
    chk("t5_dyn_acc", 32'(dyn), 32'(ACC_EN));
    end_tick();
    chk("t5_one_tick_done", 32'(done), 32'h1);
    chk("t5_one_step", 32'(step), 32'h0);
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("t5_start_stop", 32'(state), 32'(ST_IDLE));
    cyc();
    chk("t5_start_stop_busy", 32'(busy), 32'h0);

    // table writes while playing
    wr(1, 8'h12, 4'd0, 1'b0);
    num_steps = 4'd2; loop_en = 1'b1;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    start_play();
    chk("t5_p0", 32'(period), 32'h11);
    end_tick();
    cyc();
    chk("t5_p1", 32'(period), 32'h12);
    chk("t6_dyn_step1", 32'(dyn), 32'h0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h77);
    wr(1, 8'h77, 4'd0, 1'b0);
    chk("t5_wr_no_effect", 32'(period), 32'h12);
    end_tick();
    cyc();
    chk("t5_pass2_p0", 32'(period), 32'h11);
    chk("t6_dyn_step0", 32'(dyn), 32'(ACC_EN));
    end_tick();
    cyc();
    chk("t5_pass2_p1_new", 32'(period), 32'h77);
    end_tick();
    exp_q.push_back(8'h11);
    wr(0, 8'h99, 4'd0, 1'b1);
    chk("t5_load_reads_old", 32'(period), 32'h11);
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h99);
    end_tick();
    cyc();
    end_tick();
    cyc();
    chk("t5_p0_new", 32'(period), 32'h99);
    do_stop();

    // reset mid-PLAY clears outputs and table
    wr(0, 8'h66, 4'd3, 1'b1);
    tempo = 8'd5; num_steps = 4'd1; loop_en = 1'b0;
    exp_q.push_back(8'h66);
    start_play();
    chk("t1_playing", 32'(pluck), 32'h1);
    run_ticks(1);
    rst = 1'b1;
    cyc();
    cyc();
    chk("t1_period", 32'(period), 32'h0);
    chk("t1_pluck", 32'(pluck), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_dyn", 32'(dyn), 32'h0);
    chk("t1_state", 32'(state), 32'(ST_IDLE));
    rst = 1'b0;
    cyc();
    start_play();
    chk("t1_table_rest_pluck", 32'(pluck), 32'h0);
    chk("t1_table_period", 32'(period), 32'h0);
    run_ticks(4);
    end_tick();
    chk("t1_done", 32'(done), 32'h1);

    cyc();
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
